// File: rtl/sync_ram_pkg.sv
// Shared types and constants for the clocked scratch RAM.
// Optional parity storage is enabled with SYNC_RAM_PARITY_EN.
package sync_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int MAX_READ_LATENCY = 4;

    function automatic int byte_lanes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/ram_delay_line.sv
// Valid+data shift pipeline with synchronous active-low flush.
// Data of each stage only moves with a valid beat, so the output holds.
module ram_delay_line #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             flush_ni,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             vld_q  [DEPTH];
    logic [WIDTH-1:0] dat_q  [DEPTH];
    logic             vld_in [DEPTH];
    logic [WIDTH-1:0] dat_in [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_link
        if (g == 0) begin : g_head
            assign vld_in[g] = valid_i;
            assign dat_in[g] = data_i;
        end else begin : g_body
            assign vld_in[g] = vld_q[g-1];
            assign dat_in[g] = dat_q[g-1];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!flush_ni) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end else begin
                vld_q[i] <= vld_in[i];
                if (vld_in[i]) begin
                    dat_q[i] <= dat_in[i];
                end
            end
        end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign data_o  = dat_q[DEPTH-1];

endmodule

// File: rtl/sync_ram_ctrl.sv
// Clocked single-port scratch RAM: post-reset clear, byte enables, pipelined reads.
// Define SYNC_RAM_PARITY_EN to add per-byte even parity and the rsp_perr output.
module sync_ram_ctrl
    import sync_ram_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_be,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      init_done
`ifdef SYNC_RAM_PARITY_EN
    ,
    output logic [DATA_WIDTH/8-1:0]   rsp_perr
`endif
);

    localparam int NB    = byte_lanes(DATA_WIDTH);
    localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef SYNC_RAM_PARITY_EN
    localparam int PIPE_W = DATA_WIDTH + NB;
`else
    localparam int PIPE_W = DATA_WIDTH;
`endif

    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY ||
        (DATA_WIDTH % 8) != 0) begin : g_bad_param
        $error("sync_ram_ctrl: illegal READ_LATENCY or DATA_WIDTH");
    end

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] clr_addr_q;
    logic                  req_ready_q;
    logic                  init_done_q;

    logic accept;
    logic wr_en;
    logic rd_en;

    assign accept = req_valid && req_ready_q;
    assign wr_en  = accept && req_we;
    assign rd_en  = accept && !req_we;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_CLEAR;
            clr_addr_q  <= '0;
            req_ready_q <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_CLEAR: begin
                    clr_addr_q <= clr_addr_q + 1'b1;
                    if (clr_addr_q == '1) begin
                        state_q     <= ST_RUN;
                        req_ready_q <= 1'b1;
                        init_done_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_CLEAR;
                end
            endcase
        end
    end

    // Array carries no reset; the clear sequence owns its initial contents.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
`ifdef SYNC_RAM_PARITY_EN
    logic [NB-1:0]         par_q [DEPTH];
`endif

    always_ff @(posedge clock) begin
        if (reset_n) begin
            if (state_q == ST_CLEAR) begin
                mem_q[clr_addr_q] <= '0;
`ifdef SYNC_RAM_PARITY_EN
                par_q[clr_addr_q] <= '0;
`endif
            end else if (wr_en) begin
                for (int i = 0; i < NB; i++) begin
                    if (req_be[i]) begin
                        mem_q[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
`ifdef SYNC_RAM_PARITY_EN
                        par_q[req_addr][i] <= ^req_wdata[8*i +: 8];
`endif
                    end
                end
            end
        end
    end

    logic [PIPE_W-1:0] rd_word;

`ifdef SYNC_RAM_PARITY_EN
    logic [NB-1:0] rd_perr;

    always_comb begin
        rd_perr = '0;
        for (int i = 0; i < NB; i++) begin
            rd_perr[i] = (^mem_q[req_addr][8*i +: 8]) ^ par_q[req_addr][i];
        end
        rd_word = {rd_perr, mem_q[req_addr]};
    end
`else
    always_comb begin
        rd_word = mem_q[req_addr];
    end
`endif

    logic              rd_valid_q;
    logic [PIPE_W-1:0] rd_data_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= rd_word;
            end
        end
    end

    logic              pipe_valid;
    logic [PIPE_W-1:0] pipe_data;

    if (READ_LATENCY > 1) begin : g_delay
        ram_delay_line #(
            .WIDTH (PIPE_W),
            .DEPTH (READ_LATENCY - 1)
        ) u_delay (
            .clk_i    (clock),
            .flush_ni (reset_n),
            .valid_i  (rd_valid_q),
            .data_i   (rd_data_q),
            .valid_o  (pipe_valid),
            .data_o   (pipe_data)
        );
    end else begin : g_direct
        assign pipe_valid = rd_valid_q;
        assign pipe_data  = rd_data_q;
    end

    assign req_ready = req_ready_q;
    assign init_done = init_done_q;
    assign rsp_valid = pipe_valid;
    assign rsp_rdata = pipe_data[DATA_WIDTH-1:0];
`ifdef SYNC_RAM_PARITY_EN
    assign rsp_perr  = pipe_data[PIPE_W-1 -: NB];
`endif

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Randomised bench for sync_ram_ctrl against a word-array reference model.
// Parity checks are compiled in with SYNC_RAM_PARITY_EN.
module tb_sync_ram_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int RL    = 3;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic          clock     = 1'b0;
    logic          reset_n   = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we    = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [NB-1:0] req_be    = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
`ifdef SYNC_RAM_PARITY_EN
    logic [NB-1:0] rsp_perr;
`endif

    always #5 clock = ~clock;

    sync_ram_ctrl #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .READ_LATENCY (RL)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done)
`ifdef SYNC_RAM_PARITY_EN
        ,
        .rsp_perr  (rsp_perr)
`endif
    );

    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic [NB-1:0] perr;
    } rsp_t;

    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    logic [DW-1:0] m_mem [DEPTH];
    logic [NB-1:0] m_bad [DEPTH];
    int            m_clr = 0;
    bit            m_run = 1'b0;
    logic [DW-1:0] m_last = '0;
    rsp_t          m_q [$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Reference: memory is a plain word array, responses a due-cycle queue.
    task automatic model_edge();
        rsp_t r;
        if (!reset_n) begin
            m_clr  = 0;
            m_run  = 1'b0;
            m_last = '0;
            m_q.delete();
            for (int a = 0; a < DEPTH; a++) begin
                m_mem[a] = '0;
                m_bad[a] = '0;
            end
        end else if (!m_run) begin
            m_clr++;
            if (m_clr == DEPTH) m_run = 1'b1;
        end else if (req_valid) begin
            if (req_we) begin
                for (int i = 0; i < NB; i++) begin
                    if (req_be[i]) begin
                        m_mem[req_addr][8*i +: 8] = req_wdata[8*i +: 8];
                        m_bad[req_addr][i] = 1'b0;
                    end
                end
            end else begin
                r.due  = cyc + RL - 1;
                r.data = m_mem[req_addr];
                r.perr = m_bad[req_addr];
                m_q.push_back(r);
            end
        end
    endtask

    task automatic check_outputs();
        rsp_t r;
        bit   exp_v;
        exp_v = 1'b0;
        r.perr = '0;
        if (m_q.size() > 0 && m_q[0].due == cyc) begin
            r = m_q.pop_front();
            exp_v = 1'b1;
            m_last = r.data;
        end
        check("rsp_valid", rsp_valid, exp_v);
        check("rsp_rdata", rsp_rdata, m_last);
        check("req_ready", req_ready, m_run);
        check("init_done", init_done, m_run);
`ifdef SYNC_RAM_PARITY_EN
        if (exp_v) check("rsp_perr", rsp_perr, r.perr);
`endif
    endtask

    task automatic step();
        @(posedge clock);
        cyc++;
        model_edge();
        @(negedge clock);
        check_outputs();
    endtask

    task automatic drive(input bit v, input bit we, input int addr,
                         input logic [DW-1:0] d, input logic [NB-1:0] be);
        req_valid = v;
        req_we    = we;
        req_addr  = AW'(addr);
        req_wdata = d;
        req_be    = be;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 0, '0, '0);
        repeat (n) step();
    endtask

    task automatic wr(input int addr, input logic [DW-1:0] d,
                      input logic [NB-1:0] be);
        drive(1'b1, 1'b1, addr, d, be);
        step();
    endtask

    task automatic rd(input int addr);
        drive(1'b1, 1'b0, addr, $urandom, NB'($urandom));
        step();
    endtask

    // Waits out the clear phase with junk requests; returns cycles to init_done.
    task automatic wait_clear(output int len);
        int rel;
        rel = cyc;
        len = -1;
        for (int i = 0; i < DEPTH + 4; i++) begin
            drive(1'b1, 1'(($urandom)), int'($urandom_range(0, DEPTH - 1)),
                  $urandom, NB'($urandom));
            step();
            if (init_done === 1'b1) begin
                len = cyc - rel;
                break;
            end
        end
        idle(1);
    endtask

`ifdef SYNC_RAM_PARITY_EN
    task automatic flip_bit(input int addr, input int bit_idx);
        dut.mem_q[addr][bit_idx] = ~dut.mem_q[addr][bit_idx];
        m_mem[addr][bit_idx] = ~m_mem[addr][bit_idx];
        m_bad[addr][bit_idx/8] = ~m_bad[addr][bit_idx/8];
    endtask
`endif

    initial begin
        int len;
        logic [DW-1:0] d;

        reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
        wait_clear(len);
        check("clr_len", len, DEPTH);

        for (int a = 0; a < DEPTH; a++) rd(a);
        idle(RL + 1);

        wr(3, 32'hAABBCCDD, 4'b1111);
        wr(3, 32'h11223344, 4'b0101);
        rd(3);
        idle(RL + 1);
        check("be_merge", rsp_rdata, 32'hAA22CC44);

        wr(3, 32'hFFFFFFFF, 4'b0000);
        rd(3);
        idle(RL + 1);
        check("be_none", rsp_rdata, 32'hAA22CC44);

        for (int a = 0; a < 8; a++) wr(a, $urandom, 4'hF);
        for (int a = 0; a < 8; a++) rd(a);
        idle(RL + 1);

        wr(9, 32'hDEADBEEF, 4'hF);
        rd(9);
        idle(RL + 1);
        check("raw_next", rsp_rdata, 32'hDEADBEEF);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom),
                  int'($urandom_range(0, DEPTH - 1)), $urandom, NB'($urandom));
            step();
        end
        idle(RL + 1);

        wr(5, $urandom | 32'h1, 4'hF);
        rd(5);
        rd(5);
        reset_n = 1'b0;
        idle(2);
        check("rst_rdata", rsp_rdata, 32'h0);
        reset_n = 1'b1;
        wait_clear(len);
        check("clr_len2", len, DEPTH);
        d = $urandom | 32'h100;
        wr(6, d, 4'hF);
        rd(6);
        idle(RL + 1);
        check("post_rst_wr", rsp_rdata, d);
        rd(5);
        idle(RL + 1);
        check("post_rst_clr", rsp_rdata, 32'h0);

`ifdef SYNC_RAM_PARITY_EN
        wr(0, 32'h000000FF, 4'hF);
        idle(1);
        flip_bit(0, 0);
        rd(0);
        len = -1;
        for (int i = 0; i < RL + 2; i++) begin
            drive(1'b0, 1'b0, 0, '0, '0);
            step();
            if (rsp_valid === 1'b1 && len < 0) begin
                len = i;
                check("perr_flip", rsp_perr, 4'b0001);
            end
        end
        check("perr_seen", len >= 0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
